// File: rtl/bsg_fifo_1r1w_synth_param.sv
// Single-clock, one-read/one-write FIFO built from a register array.
// Head word is visible one cycle after it is enqueued; there is no fall-through.
// ready_o and v_o depend only on the stored count (and reset), never on v_i/yumi_i.
module bsg_fifo_1r1w_synth_param #(
  parameter int width_p = 30,
  parameter int els_p   = 2,
  localparam int lg_els_lp = $clog2(els_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,

  input  logic                 v_i,
  input  logic [width_p-1:0]   data_i,
  output logic                 ready_o,

  output logic                 v_o,
  output logic [width_p-1:0]   data_o,
  input  logic                 yumi_i,

  output logic [lg_els_lp-1:0] count_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  typedef logic [ptr_w_lp-1:0]  ptr_t;
  typedef logic [lg_els_lp-1:0] cnt_t;

  localparam ptr_t last_ptr_lp = ptr_t'(els_p - 1);
  localparam cnt_t full_cnt_lp = cnt_t'(els_p);

  logic [width_p-1:0] mem_q [els_p];

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  cnt_t count_q, count_d;

  logic enq, deq;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == last_ptr_lp) ? '0 : p + ptr_t'(1);
  endfunction

  // Handshake flags come from the count only; reset holds ready_o low.
  assign ready_o = ~reset_i & (count_q != full_cnt_lp);
  assign v_o     = (count_q != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign count_o = count_q;

  // Head word is gated to zero whenever the FIFO is empty.
  assign data_o  = v_o ? mem_q[rptr_q] : '0;

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (enq) wptr_d = ptr_inc(wptr_q);
    if (deq) rptr_d = ptr_inc(rptr_q);

    unique case ({enq, deq})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; a full FIFO never accepts, so the write slot never equals
  // the slot being read in the same cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: the array is deliberately not reset; v_o/data_o gating makes stale
    // contents invisible, and leaving it out keeps the array plain flops.
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: tb/tb_bsg_fifo_1r1w_synth_param.sv
// Self-checking bench: three FIFO configurations checked every cycle against
// queue-based reference models, plus directed scenarios with literal values.
module tb_bsg_fifo_1r1w_synth_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Instance 0: width 30, depth 2
  logic        v0 = 0, y0 = 0, r0, vo0;
  logic [29:0] d0 = '0, do0;
  logic [1:0]  c0;
  // Instance 1: width 8, depth 3
  logic        v1 = 0, y1 = 0, r1, vo1;
  logic [7:0]  d1 = '0, do1;
  logic [1:0]  c1;
  // Instance 2: width 16, depth 8
  logic        v2 = 0, y2 = 0, r2, vo2;
  logic [15:0] d2 = '0, do2;
  logic [3:0]  c2;

  bsg_fifo_1r1w_synth_param #(.width_p(30), .els_p(2)) u0 (
    .clk_i(clk), .reset_i(rst), .v_i(v0), .data_i(d0), .ready_o(r0),
    .v_o(vo0), .data_o(do0), .yumi_i(y0), .count_o(c0));

  bsg_fifo_1r1w_synth_param #(.width_p(8), .els_p(3)) u1 (
    .clk_i(clk), .reset_i(rst), .v_i(v1), .data_i(d1), .ready_o(r1),
    .v_o(vo1), .data_o(do1), .yumi_i(y1), .count_o(c1));

  bsg_fifo_1r1w_synth_param #(.width_p(16), .els_p(8)) u2 (
    .clk_i(clk), .reset_i(rst), .v_i(v2), .data_i(d2), .ready_o(r2),
    .v_o(vo2), .data_o(do2), .yumi_i(y2), .count_o(c2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference models: plain queues; enqueue allowed when not full (pre-edge),
  // dequeue allowed when not empty; reset empties everything.
  logic [29:0] q0[$], q1[$], q2[$];

  always @(posedge clk or posedge rst) begin
    bit e, d;
    if (rst) q0.delete();
    else begin
      e = v0 && (q0.size() < 2);
      d = y0 && (q0.size() > 0);
      if (d) void'(q0.pop_front());
      if (e) q0.push_back(d0);
    end
  end

  always @(posedge clk or posedge rst) begin
    bit e, d;
    if (rst) q1.delete();
    else begin
      e = v1 && (q1.size() < 3);
      d = y1 && (q1.size() > 0);
      if (d) void'(q1.pop_front());
      if (e) q1.push_back(30'(d1));
    end
  end

  always @(posedge clk or posedge rst) begin
    bit e, d;
    if (rst) q2.delete();
    else begin
      e = v2 && (q2.size() < 8);
      d = y2 && (q2.size() > 0);
      if (d) void'(q2.pop_front());
      if (e) q2.push_back(30'(d2));
    end
  end

  // Compare every DUT output against its model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("u0_ready", 32'(r0),  32'(!rst && q0.size() < 2));
      check("u0_valid", 32'(vo0), 32'(q0.size() > 0));
      check("u0_count", 32'(c0),  32'(q0.size()));
      check("u0_data",  32'(do0), (q0.size() > 0) ? 32'(q0[0]) : 32'd0);
      check("u1_ready", 32'(r1),  32'(!rst && q1.size() < 3));
      check("u1_valid", 32'(vo1), 32'(q1.size() > 0));
      check("u1_count", 32'(c1),  32'(q1.size()));
      check("u1_data",  32'(do1), (q1.size() > 0) ? 32'(q1[0]) : 32'd0);
      check("u2_ready", 32'(r2),  32'(!rst && q2.size() < 8));
      check("u2_valid", 32'(vo2), 32'(q2.size() > 0));
      check("u2_count", 32'(c2),  32'(q2.size()));
      check("u2_data",  32'(do2), (q2.size() > 0) ? 32'(q2[0]) : 32'd0);
    end
  end

  // One clock edge, then settle just past the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    cmp_en = 1'b1;

    // Reset state held while reset_i is high
    check("rst_ready", 32'(r0),  32'd0);
    check("rst_valid", 32'(vo0), 32'd0);
    check("rst_count", 32'(c0),  32'd0);
    check("rst_data",  32'(do0), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(r0), 32'd1);
    check("rel_count", 32'(c0), 32'd0);

    // Basic fill / drain
    v0 = 1; d0 = 30'h0AAAAAAA;
    tick();
    check("fill1_count", 32'(c0),  32'd1);
    check("fill1_data",  32'(do0), 32'h0AAAAAAA);
    d0 = 30'h15555555;
    tick();
    v0 = 0;
    check("fill2_count", 32'(c0),  32'd2);
    check("fill2_ready", 32'(r0),  32'd0);
    check("fill2_data",  32'(do0), 32'h0AAAAAAA);
    y0 = 1;
    tick();
    check("drain1_data",  32'(do0), 32'h15555555);
    check("drain1_count", 32'(c0),  32'd1);
    tick();
    check("drain2_valid", 32'(vo0), 32'd0);
    check("drain2_data",  32'(do0), 32'd0);
    check("drain2_count", 32'(c0),  32'd0);
    // yumi while empty is ignored
    tick();
    check("yumi_empty_count", 32'(c0), 32'd0);
    y0 = 0;

    // Full + simultaneous enqueue/dequeue: enqueue blocked
    v0 = 1; d0 = 30'h11;
    tick();
    d0 = 30'h22;
    tick();
    d0 = 30'h3; y0 = 1;
    tick();
    check("full_sim_count", 32'(c0),  32'd1);
    check("full_sim_data",  32'(do0), 32'h22);
    v0 = 0;
    tick();
    check("full_sim_drain_count", 32'(c0),  32'd0);
    check("full_sim_drain_valid", 32'(vo0), 32'd0);
    y0 = 0;

    // v_i while full leaves contents unchanged
    v0 = 1; d0 = 30'h44;
    tick();
    d0 = 30'h55;
    tick();
    d0 = 30'h66;
    tick();
    v0 = 0;
    check("vfull_count", 32'(c0),  32'd2);
    check("vfull_head",  32'(do0), 32'h44);
    y0 = 1;
    tick();
    check("vfull_second", 32'(do0), 32'h55);
    tick();
    y0 = 0;
    check("vfull_empty", 32'(vo0), 32'd0);

    // Async reset mid-operation
    v0 = 1; d0 = 30'h77;
    tick();
    d0 = 30'h88;
    tick();
    v0 = 0;
    check("pre_rst_count", 32'(c0), 32'd2);
    rst = 1'b1;
    #1;
    check("async_valid", 32'(vo0), 32'd0);
    check("async_count", 32'(c0),  32'd0);
    check("async_ready", 32'(r0),  32'd0);
    check("async_data",  32'(do0), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(r0), 32'd1);
    tick();
    check("post_rst_valid", 32'(vo0), 32'd0);
    check("post_rst_count", 32'(c0),  32'd0);

    // Streaming wrap on depth-3 instance at count=1
    v1 = 1; d1 = 8'h00;
    tick();
    y1 = 1;
    for (int i = 1; i <= 9; i++) begin
      d1 = 8'(i);
      check("stream_head", 32'(do1), 32'(i - 1));
      tick();
      check("stream_count", 32'(c1), 32'd1);
    end
    v1 = 0;
    check("stream_last", 32'(do1), 32'h09);
    tick();
    y1 = 0;
    check("stream_empty", 32'(c1), 32'd0);

    // Random stress on all three configurations
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit ph;
      ph = ((cyc / 400) % 2) == 1;
      v0 = ($urandom_range(0, 3) != 0);
      y0 = ($urandom_range(0, 1) != 0);
      v1 = ($urandom_range(0, 1) != 0);
      y1 = ($urandom_range(0, 1) != 0);
      v2 = ph ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      y2 = ph ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      d0 = 30'($urandom);
      d1 = 8'($urandom);
      d2 = 16'($urandom);
      if (cyc == 6000) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      tick();
    end
    v0 = 0; y0 = 0; v1 = 0; y1 = 0; v2 = 0; y2 = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_1r1w_synth_param.md
BSG_FIFO_1R1W_SYNTH_PARAM -- requirements
Module: bsg_fifo_1r1w_synth_param

Interface
REQ-001 SHALL provide parameter width_p, default 30, meaning data word width in bits (>=1).
REQ-002 SHALL provide parameter els_p, default 2, meaning storage depth in words (>=2; non-power-of-2 legal).
REQ-003 SHALL provide parameter lg_els_lp, default $clog2(els_p+1), meaning count_o width; localparam, not overridable.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port v_i  input  1  enqueue request.
REQ-007 SHALL have port data_i  input  width_p  enqueue data.
REQ-008 SHALL have port ready_o  output  1  space available; enqueue occurs when v_i & ready_o.
REQ-009 SHALL have port v_o  output  1  head word valid.
REQ-010 SHALL have port data_o  output  width_p  head word.
REQ-011 SHALL have port yumi_i  input  1  dequeue; consumer asserts only when v_o is high.
REQ-012 SHALL have port count_o  output  lg_els_lp  number of stored words, 0..els_p.

Function
REQ-013 SHALL store words in an els_p x width_p register array with no reset on array contents.
REQ-014 SHALL keep write pointer wptr, read pointer rptr, each in 0..els_p-1, incrementing by 1 and wrapping from els_p-1 to 0.
REQ-015 SHALL write data_i to mem[wptr] and advance wptr on a clock edge where v_i & ready_o.
REQ-016 SHALL advance rptr on a clock edge where yumi_i & v_o.
REQ-017 SHALL update count_o: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-018 SHALL drive ready_o = (count_o != els_p) and v_o = (count_o != 0), both purely from registered state (no combinational path from v_i or yumi_i).
REQ-019 SHALL drive data_o = mem[rptr] when v_o is high and all-zeros when v_o is low.
REQ-020 SHALL have enqueue-to-visibility latency of one cycle: a word enqueued at edge t appears on data_o with v_o high after edge t when the FIFO was empty (no fall-through bypass).
REQ-021 SHALL, on simultaneous enqueue and dequeue with 0<count<els_p, perform both; count unchanged; wptr and rptr both advance.
REQ-022 SHALL, when full, block enqueue (ready_o low) even if yumi_i is high that cycle; a word is never written to the slot being read (read and write addresses never coincide in one cycle).
REQ-023 SHALL ignore v_i while ready_o is low: no write, no pointer or count change.
REQ-024 SHALL ignore yumi_i while v_o is low: no pointer or count change.
REQ-025 SHALL preserve FIFO order: words dequeue in exact enqueue order across any number of pointer wraps.

Reset
REQ-026 SHALL, while reset_i is high, immediately (without waiting for a clock edge) force wptr=0, rptr=0, count_o=0, v_o=0, data_o=0, ready_o=0.
REQ-027 SHALL drive ready_o=1 in the first cycle after reset_i deasserts, with count_o=0.
REQ-028 SHALL, on reset asserted mid-operation, discard all stored words; following reset release, v_o stays 0 until a new enqueue.
REQ-029 SHALL ignore v_i and yumi_i while reset_i is high.

Verification
REQ-030 Bench SHALL cover basic fill/drain (width_p=30, els_p=2): enqueue 30'h0AAAAAAA then 30'h15555555 -> count_o=2, ready_o=0, data_o=30'h0AAAAAAA; two yumi -> data_o 30'h15555555 then v_o=0, data_o=0, count_o=0.
REQ-031 Bench SHALL cover full + simultaneous: at count=2 drive v_i=1 with data 30'h3 and yumi_i=1 -> head dequeued, 30'h3 not written, count_o=1.
REQ-032 Bench SHALL cover streaming wrap (els_p=3, width_p=8): continuous enqueue/dequeue of 0x00..0x09 at count=1 -> count_o stays 1, output sequence 0x00..0x09 in order.
REQ-033 Bench SHALL cover illegal stimulus: yumi_i=1 while empty -> count_o stays 0; v_i=1 while full -> contents unchanged.
REQ-034 Bench SHALL cover async reset mid-operation: at count=2 pulse reset_i between clock edges -> v_o=0, count_o=0, ready_o=0 before next edge; ready_o=1 the cycle after release.
REQ-035 Bench SHALL cover a random ready/valid stress run of >=10000 cycles against a reference queue model for els_p in {2,3,8}, with zero ordering or count mismatches.
